// File: rtl/vga_box_painter.sv
// Pixel-colour stage behind the VGA timing counter: two-stage pipeline that paints
// blank / box / border / background and moves a bouncing box once per frame.
module vga_box_painter #(
    parameter int          H_VIS      = 640,
    parameter int          V_VIS      = 480,
    parameter int          BOX_SIZE   = 32,
    parameter int          STEP       = 2,
    parameter int          BORDER_W   = 4,
    parameter int          X0         = 0,
    parameter int          Y0         = 0,
    parameter logic [11:0] BG_RGB     = 12'h000,
    parameter logic [11:0] BORDER_RGB = 12'hFFF,
    parameter logic [11:0] BOX_RGB    = 12'hF00
) (
    input  logic        reloj,
    input  logic        resetM,
    input  logic [9:0]  Qh,
    input  logic [9:0]  Qv,
    input  logic        H_ON,
    input  logic        V_ON,
    input  logic        H_Sync,
    input  logic        V_Sync,
    input  logic        run,
    output logic [11:0] rgb,
    output logic        H_Sync_o,
    output logic        V_Sync_o,
    output logic [9:0]  box_x,
    output logic [9:0]  box_y,
    output logic        frame_tick
);

    typedef enum logic {INC = 1'b0, DEC = 1'b1} dir_t;

    logic [9:0]  qh_s1;
    logic [9:0]  qv_s1;
    logic        h_on_s1;
    logic        v_on_s1;
    logic        h_sync_s1;
    logic        v_sync_s1;
    logic        v_on_d;
    dir_t        dir_x;
    dir_t        dir_y;

    logic [10:0] qh_w;
    logic [10:0] qv_w;
    logic [10:0] bx_w;
    logic [10:0] by_w;
    logic        in_box;
    logic        on_border;
    logic [11:0] pixel;

    // 11-bit views so box_x + BOX_SIZE and friends never wrap
    assign qh_w = {1'b0, qh_s1};
    assign qv_w = {1'b0, qv_s1};
    assign bx_w = {1'b0, box_x};
    assign by_w = {1'b0, box_y};

    assign in_box = (qh_w >= bx_w) && (qh_w < bx_w + 11'(BOX_SIZE)) &&
                    (qv_w >= by_w) && (qv_w < by_w + 11'(BOX_SIZE));

    assign on_border = (qh_w < 11'(BORDER_W)) || (qh_w >= 11'(H_VIS - BORDER_W)) ||
                       (qv_w < 11'(BORDER_W)) || (qv_w >= 11'(V_VIS - BORDER_W));

    always_comb begin
        pixel = BG_RGB;
        if (!(h_on_s1 && v_on_s1)) begin
            pixel = 12'h000;
        end else if (in_box) begin
            pixel = BOX_RGB;
        end else if (on_border) begin
            pixel = BORDER_RGB;
        end
    end

    always_ff @(posedge reloj) begin
        if (resetM) begin
            qh_s1      <= '0;
            qv_s1      <= '0;
            h_on_s1    <= 1'b0;
            v_on_s1    <= 1'b0;
            h_sync_s1  <= 1'b0;
            v_sync_s1  <= 1'b0;
            v_on_d     <= 1'b0;
            rgb        <= '0;
            H_Sync_o   <= 1'b0;
            V_Sync_o   <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            qh_s1      <= Qh;
            qv_s1      <= Qv;
            h_on_s1    <= H_ON;
            v_on_s1    <= V_ON;
            h_sync_s1  <= H_Sync;
            v_sync_s1  <= V_Sync;
            v_on_d     <= v_on_s1;
            rgb        <= pixel;
            H_Sync_o   <= h_sync_s1;
            V_Sync_o   <= v_sync_s1;
            // falling edge of the stage-1 visible flag marks the end of the frame
            frame_tick <= v_on_d && !v_on_s1;
        end
    end

    // Per-axis bounce FSMs; position only moves during vertical blanking
    always_ff @(posedge reloj) begin
        if (resetM) begin
            box_x <= 10'(X0);
            box_y <= 10'(Y0);
            dir_x <= INC;
            dir_y <= INC;
        end else if (frame_tick && run) begin
            case (dir_x)
                INC: begin
                    if (bx_w + 11'(BOX_SIZE + STEP) <= 11'(H_VIS)) begin
                        box_x <= box_x + 10'(STEP);
                    end else begin
                        box_x <= box_x - 10'(STEP);
                        dir_x <= DEC;
                    end
                end
                DEC: begin
                    if (box_x >= 10'(STEP)) begin
                        box_x <= box_x - 10'(STEP);
                    end else begin
                        box_x <= box_x + 10'(STEP);
                        dir_x <= INC;
                    end
                end
            endcase
            case (dir_y)
                INC: begin
                    if (by_w + 11'(BOX_SIZE + STEP) <= 11'(V_VIS)) begin
                        box_y <= box_y + 10'(STEP);
                    end else begin
                        box_y <= box_y - 10'(STEP);
                        dir_y <= DEC;
                    end
                end
                DEC: begin
                    if (box_y >= 10'(STEP)) begin
                        box_y <= box_y - 10'(STEP);
                    end else begin
                        box_y <= box_y + 10'(STEP);
                        dir_y <= INC;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vga_box_painter.sv
// Bench for vga_box_painter: table of priority vectors, directed frame/bounce/reset
// sequences, and randomized cycles checked against a behavioural model.
module tb_vga_box_painter;

    localparam int          H_VIS      = 640;
    localparam int          V_VIS      = 480;
    localparam int          BOX_SIZE   = 32;
    localparam int          STEP       = 2;
    localparam int          BORDER_W   = 4;
    localparam int          X0         = 0;
    localparam int          Y0         = 0;
    localparam logic [11:0] BG_RGB     = 12'h000;
    localparam logic [11:0] BORDER_RGB = 12'hFFF;
    localparam logic [11:0] BOX_RGB    = 12'hF00;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  qh;
    logic [9:0]  qv;
    logic        hon;
    logic        von;
    logic        hs;
    logic        vs;
    logic        run;
    logic [11:0] rgb;
    logic        hs_o;
    logic        vs_o;
    logic [9:0]  box_x;
    logic [9:0]  box_y;
    logic        frame_tick;

    vga_box_painter #(
        .H_VIS(H_VIS), .V_VIS(V_VIS), .BOX_SIZE(BOX_SIZE), .STEP(STEP),
        .BORDER_W(BORDER_W), .X0(X0), .Y0(Y0), .BG_RGB(BG_RGB),
        .BORDER_RGB(BORDER_RGB), .BOX_RGB(BOX_RGB)
    ) dut (
        .reloj(clk), .resetM(rst), .Qh(qh), .Qv(qv), .H_ON(hon), .V_ON(von),
        .H_Sync(hs), .V_Sync(vs), .run(run), .rgb(rgb), .H_Sync_o(hs_o),
        .V_Sync_o(vs_o), .box_x(box_x), .box_y(box_y), .frame_tick(frame_tick)
    );

    // clock / reset block
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // scoreboard: expected {H_Sync_o, V_Sync_o, rgb} per cycle
    logic [13:0] exp_q[$];

    // behavioural model state
    int m_bx = X0, m_by = Y0, m_dx = 1, m_dy = 1;
    bit m_tick = 0;
    int p_qh = 0, p_qv = 0;
    bit p_hon = 0, p_von = 0, p_hs = 0, p_vs = 0, pp_von = 0;

    typedef struct {
        logic [9:0]  qh;
        logic [9:0]  qv;
        logic        hon;
        logic        von;
        logic [11:0] exp_rgb;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    function automatic logic [11:0] colour(int x, int y, bit h_on, bit v_on, int bx, int by);
        if (!(h_on && v_on)) return 12'h000;
        if (x >= bx && x < bx + BOX_SIZE && y >= by && y < by + BOX_SIZE) return BOX_RGB;
        if (x < BORDER_W || x >= H_VIS - BORDER_W || y < BORDER_W || y >= V_VIS - BORDER_W)
            return BORDER_RGB;
        return BG_RGB;
    endfunction

    task automatic bounce(inout int pos, inout int dir, input int lim);
        if (dir > 0) begin
            if (pos + BOX_SIZE + STEP <= lim) pos += STEP;
            else begin pos -= STEP; dir = -1; end
        end else begin
            if (pos >= STEP) pos -= STEP;
            else begin pos += STEP; dir = 1; end
        end
    endtask

    // what the outputs must be after the clock edge that sampled the current inputs
    task automatic model_edge();
        bit new_tick;
        if (rst) begin
            exp_q.push_back(14'h0);
            m_tick = 0;
            m_bx = X0; m_by = Y0; m_dx = 1; m_dy = 1;
            p_qh = 0; p_qv = 0; p_hon = 0; p_von = 0; p_hs = 0; p_vs = 0; pp_von = 0;
        end else begin
            exp_q.push_back({p_hs, p_vs, colour(p_qh, p_qv, p_hon, p_von, m_bx, m_by)});
            new_tick = pp_von && !p_von;
            if (m_tick && run) begin
                bounce(m_bx, m_dx, H_VIS);
                bounce(m_by, m_dy, V_VIS);
            end
            pp_von = p_von;
            p_qh = int'(qh); p_qv = int'(qv);
            p_hon = hon; p_von = von; p_hs = hs; p_vs = vs;
            m_tick = new_tick;
        end
    endtask

    task automatic step();
        logic [13:0] e;
        @(posedge clk);
        model_edge();
        #1;
        e = exp_q.pop_front();
        chk("rgb", 32'(rgb), 32'(e[11:0]));
        chk("h_sync_o", 32'(hs_o), 32'(e[13]));
        chk("v_sync_o", 32'(vs_o), 32'(e[12]));
        chk("frame_tick", 32'(frame_tick), 32'(m_tick));
        chk("box_x", 32'(box_x), 32'(m_bx));
        chk("box_y", 32'(box_y), 32'(m_by));
    endtask

    // one frame: visible for 3 cycles, blank for 3; counts tick pulses seen
    task automatic frame(output int ticks);
        ticks = 0;
        hon = 1'b1;
        for (int i = 0; i < 6; i++) begin
            von = (i < 3);
            qh = 10'($urandom_range(0, 799));
            qv = 10'($urandom_range(0, 524));
            step();
            if (frame_tick) ticks++;
        end
    endtask

    initial begin
        int t;
        int n;
        vecs[0]  = '{10'd10,  10'd10,  1'b1, 1'b1, 12'hF00};
        vecs[1]  = '{10'd2,   10'd200, 1'b1, 1'b1, 12'hFFF};
        vecs[2]  = '{10'd639, 10'd479, 1'b1, 1'b1, 12'hFFF};
        vecs[3]  = '{10'd100, 10'd100, 1'b0, 1'b1, 12'h000};
        vecs[4]  = '{10'd100, 10'd100, 1'b1, 1'b1, 12'h000};
        vecs[5]  = '{10'd636, 10'd100, 1'b1, 1'b1, 12'hFFF};
        vecs[6]  = '{10'd635, 10'd100, 1'b1, 1'b1, 12'h000};
        vecs[7]  = '{10'd31,  10'd31,  1'b1, 1'b1, 12'hF00};
        vecs[8]  = '{10'd32,  10'd10,  1'b1, 1'b1, 12'h000};
        vecs[9]  = '{10'd32,  10'd2,   1'b1, 1'b1, 12'hFFF};
        vecs[10] = '{10'd100, 10'd476, 1'b1, 1'b1, 12'hFFF};
        vecs[11] = '{10'd100, 10'd475, 1'b1, 1'b1, 12'h000};

        rst = 1'b1; qh = '0; qv = '0; hon = 1'b0; von = 1'b0;
        hs = 1'b0; vs = 1'b0; run = 1'b0;

        // reset held 5 cycles: every output at its reset value
        for (int i = 0; i < 5; i++) begin
            step();
            chk("reset_rgb", 32'(rgb), 32'h0);
            chk("reset_box", 32'({box_x, box_y}), 32'({10'(X0), 10'(Y0)}));
            chk("reset_tick", 32'(frame_tick), 32'h0);
        end
        rst = 1'b0;
        qh = 10'd100; qv = 10'd100; hon = 1'b1; von = 1'b1; hs = 1'b1;
        step();
        hs = 1'b0;
        chk("hsync_lat1", 32'(hs_o), 32'h0);
        step();
        chk("hsync_lat2", 32'(hs_o), 32'h1);
        chk("rgb_lat2", 32'(rgb), 32'(BG_RGB));
        step();
        chk("hsync_lat3", 32'(hs_o), 32'h0);

        // priority table
        for (int i = 0; i < 12; i++) begin
            qh = vecs[i].qh; qv = vecs[i].qv; hon = vecs[i].hon; von = vecs[i].von;
            step();
            step();
            chk($sformatf("prio%0d", i), 32'(rgb), 32'(vecs[i].exp_rgb));
        end

        // frame motion
        run = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            frame(t);
            chk("motion_ticks", 32'(t), 32'd1);
            chk("motion_x", 32'(box_x), 32'(2 * i));
            chk("motion_y", 32'(box_y), 32'(2 * i));
        end

        // right-edge bounce
        n = 0;
        while (m_bx != 608 && n < 400) begin frame(t); n++; end
        chk("reach_608", 32'(box_x), 32'd608);
        frame(t);
        chk("bounce_606", 32'(box_x), 32'd606);
        frame(t);
        chk("bounce_604", 32'(box_x), 32'd604);

        // left bounce, then freeze and resume
        n = 0;
        while (m_bx != 0 && n < 400) begin frame(t); n++; end
        chk("reach_0", 32'(box_x), 32'd0);
        frame(t);
        chk("bounce_2", 32'(box_x), 32'd2);
        run = 1'b0;
        for (int i = 0; i < 3; i++) begin
            frame(t);
            chk("frozen_tick", 32'(t), 32'd1);
            chk("frozen_x", 32'(box_x), 32'd2);
        end
        run = 1'b1;
        frame(t);
        chk("resume_x", 32'(box_x), 32'd4);

        // reset in the same cycle as frame_tick
        hon = 1'b1; von = 1'b1;
        step(); step(); step();
        von = 1'b0;
        step(); step();
        chk("pre_reset_tick", 32'(frame_tick), 32'h1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midreset_box", 32'({box_x, box_y}), 32'({10'(X0), 10'(Y0)}));
        chk("midreset_rgb", 32'(rgb), 32'h0);
        chk("midreset_tick", 32'(frame_tick), 32'h0);

        // randomized cycles
        for (int i = 0; i < 3000; i++) begin
            qh = 10'($urandom_range(0, 799));
            qv = 10'($urandom_range(0, 524));
            hon = 1'($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0) von = ~von;
            if ($urandom_range(0, 31) == 0) run = ~run;
            hs = 1'($urandom_range(0, 1));
            vs = 1'($urandom_range(0, 1));
            rst = ($urandom_range(0, 299) == 0);
            step();
        end
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
